// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional checksum stage is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StSync,
    StCntLo,
    StCntHi,
    StData,
    StWrite,
    StDone,
    StErr
`ifdef IMEM_LOADER_CHECKSUM_EN
    , StChk
`endif
  } loaderState_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rxState_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Single-cycle instruction-memory write port driven by the boot loader.
interface imem_uart_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input imem_we, input imem_addr, input imem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxSerial,
  output logic       rxValid,
  output logic [7:0] rxByte,
  output logic       rxFerr
);
  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(ClksPerBit - 1);

  rxState_e        stateQ, stateD;
  logic [2:0]      syncQ;  // [0],[1] synchronizer, [2] previous synced level
  logic [CntW-1:0] cntQ;
  logic [2:0]      bitIdxQ;
  logic [7:0]      shiftQ;
  logic            rxBit, fall, tick;

  assign rxBit = syncQ[1];
  assign fall  = syncQ[2] & ~rxBit;
  assign tick  = (stateQ == RxStart) ? (cntQ == HalfM1) : (cntQ == BitM1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= RxIdle;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      RxIdle:  if (fall) stateD = RxStart;
      RxStart: if (tick) stateD = rxBit ? RxIdle : RxData;
      RxData:  if (tick && bitIdxQ == 3'd7) stateD = RxStop;
      RxStop:  if (tick) stateD = RxIdle;
      default: stateD = RxIdle;
    endcase
  end

  always_comb begin
    rxValid = (stateQ == RxStop) && tick && rxBit;
    rxFerr  = (stateQ == RxStop) && tick && !rxBit;
    rxByte  = shiftQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ   <= 3'b111;
      cntQ    <= '0;
      bitIdxQ <= '0;
      shiftQ  <= '0;
    end else begin
      syncQ <= {syncQ[1:0], rxSerial};
      if (stateQ == RxIdle || tick) cntQ <= '0;
      else                          cntQ <= cntQ + 1'b1;
      if (stateQ == RxIdle) begin
        bitIdxQ <= '0;
      end else if (stateQ == RxData && tick) begin
        bitIdxQ <= bitIdxQ + 1'b1;
        shiftQ  <= {rxBit, shiftQ[7:1]};
      end
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed program image over UART and writes it into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned MAX_WORDS   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx_i,
  imem_uart_loader_if.master        imem,
  output logic                      cpu_hold,
  output logic                      load_done,
  output logic                      load_err,
  output logic [15:0]               words_loaded
);
  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [16:0] MaxWords   = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loaderState_e AfterLast = StChk;
`else
  localparam loaderState_e AfterLast = StDone;
`endif

  logic         rxValid, rxFerr;
  logic [7:0]   rxByte;
  loaderState_e stateQ, stateD;
  logic [7:0]   cntLoQ;
  logic [15:0]  countQ, wordIdxQ, wordsLoadedQ;
  logic [1:0]   byteIdxQ;
  logic [31:0]  wordBufQ, addrQ, wdataQ;
  logic [15:0]  newCount;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]   xsumQ;
`endif

  uart_rx_byte #(
    .ClksPerBit(ClksPerBit)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxSerial (uart_rx_i),
    .rxValid  (rxValid),
    .rxByte   (rxByte),
    .rxFerr   (rxFerr)
  );

  assign newCount = {rxByte, cntLoQ};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= StSync;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    if (rxFerr && stateQ != StDone) begin
      stateD = StErr;
    end else begin
      unique case (stateQ)
        StSync:  if (rxValid && rxByte == SYNC_BYTE) stateD = StCntLo;
        StCntLo: if (rxValid) stateD = StCntHi;
        StCntHi: begin
          if (rxValid) begin
            if (newCount == 16'd0)                stateD = AfterLast;
            else if ({1'b0, newCount} > MaxWords) stateD = StErr;
            else                                  stateD = StData;
          end
        end
        StData:  if (rxValid && byteIdxQ == 2'd3) stateD = StWrite;
        StWrite: stateD = (wordIdxQ + 16'd1 == countQ) ? AfterLast : StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk:   if (rxValid) stateD = (rxByte == xsumQ) ? StDone : StErr;
`endif
        StDone:  stateD = StDone;
        StErr:   stateD = StErr;
        default: stateD = StErr;
      endcase
    end
  end

  // Status is decoded from the state register, so hold drops on the edge that sets done.
  always_comb begin
    imem.imem_we = (stateQ == StWrite);
    cpu_hold     = (stateQ != StDone);
    load_done    = (stateQ == StDone);
    load_err     = (stateQ == StErr);
  end

  assign imem.imem_addr  = addrQ;
  assign imem.imem_wdata = wdataQ;
  assign words_loaded    = wordsLoadedQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntLoQ       <= '0;
      countQ       <= '0;
      wordIdxQ     <= '0;
      wordsLoadedQ <= '0;
      byteIdxQ     <= '0;
      wordBufQ     <= '0;
      addrQ        <= '0;
      wdataQ       <= '0;
    end else begin
      unique case (stateQ)
        StCntLo: if (rxValid) cntLoQ <= rxByte;
        StCntHi: begin
          if (rxValid) begin
            countQ   <= newCount;
            byteIdxQ <= '0;
            wordIdxQ <= '0;
          end
        end
        StData: begin
          if (rxValid) begin
            wordBufQ <= {rxByte, wordBufQ[31:8]};
            byteIdxQ <= byteIdxQ + 1'b1;
            if (byteIdxQ == 2'd3) begin
              addrQ  <= {14'd0, wordIdxQ, 2'b00};
              wdataQ <= {rxByte, wordBufQ[31:8]};
            end
          end
        end
        StWrite: begin
          wordIdxQ     <= wordIdxQ + 16'd1;
          wordsLoadedQ <= wordsLoadedQ + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsumQ <= '0;
    end else if (rxValid) begin
      if (stateQ == StCntLo)                         xsumQ <= rxByte;
      else if (stateQ == StCntHi || stateQ == StData) xsumQ <= xsumQ ^ rxByte;
    end
  end
`endif

endmodule
